unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbiter and sequencer that shares one single-port, fixed-latency memory between the instruction-fetch stage and the MEM-stage data access of the 4-stage MIPS pipeline. It grants one requester at a time, holds the memory command for the configured latency, and returns read data with a one-cycle acknowledge. It also produces the stall signals that freeze the PC/IF-ID path or the whole pipeline while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `WAIT_CYCLES`, 2, memory latency in cycles. Legal range 1..15. Counter width is 4 bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req` is high.
- `if_rdata`  out  DATA_W  fetched instruction; valid when `if_ack` is high.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load data; valid when `d_ack` is high.
- `d_ack`  out  1  one-cycle data completion pulse.
- `mem_en`  out  1  memory command valid.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid in the last cycle of a held command.
- `stall_if`  out  1  freeze PC and IF/ID: `if_req & ~if_ack`.
- `stall_all`  out  1  freeze all pipeline registers: `d_req & ~d_ack`.

## Operation
- FSM states are IDLE, IF_BUSY, D_BUSY and RESP.
- **IDLE:** if no request is present, stay in IDLE.
  - If exactly one requester is active, grant it.
  - If both are active, apply the tie rule in Configuration.
  - On a grant: latch address, write enable and write data into command registers; set `cnt = WAIT_CYCLES-1`; go to IF_BUSY or D_BUSY; record `last_grant`.
- **IF_BUSY / D_BUSY:**
  - Drive `mem_en=1` and the latched command. `mem_we` is forced to 0 in IF_BUSY.
  - Decrement `cnt` each cycle.
  - At `cnt==0`: for a load or fetch, capture `mem_rdata` into the granted requester's rdata register. Then go to RESP.
- **RESP:**
  - `mem_en=0`.
  - Assert the granted ack for exactly one cycle.
  - Requests are not sampled in RESP.
  - Next state is IDLE.
- A store does not update `d_rdata`; it keeps its prior value.
- Request inputs are not re-sampled during BUSY states. Dropping `req` mid-transaction does not abort it; the ack is still issued.
- All outputs other than `stall_if` and `stall_all` are registered.

## Timing
- Reset values: state IDLE, `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `if_ack=0`, `d_ack=0`, `if_rdata=0`, `d_rdata=0`, `cnt=0`, `last_grant=IF`.
- Reset asserted mid-transaction abandons it:
  - `mem_en=0` from the next edge.
  - No ack is issued.
  - rdata registers are cleared.
- Request sampled in IDLE at edge N:
  - `mem_en` is high for cycles N+1..N+WAIT_CYCLES.
  - The ack pulses in cycle N+WAIT_CYCLES+1.
- Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- The requester must deassert `req` in the cycle `ack` is seen, or the next IDLE re-grants it.
- `stall_*` are combinational from `req` and `ack`. They fall in the ack cycle.

## Configuration
- Macro: `ARB_DATA_PRIORITY_EN`.
- **Defined:** on a tie, data always wins (fixed priority). The oldest instruction progresses first; fetch can starve under continuous data traffic.
- **Undefined:** on a tie, grant the requester that is not `last_grant` (round-robin). After reset, the first tie goes to data.
- A single requester is always granted immediately in both modes.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles → all outputs 0, state IDLE.
- **Fetch:** WAIT_CYCLES=2, `if_req` with `if_addr=0x40`, memory returns `0x8C220004` → `mem_en` high for 2 cycles with `mem_addr=0x40`; `if_ack` is high in cycle 3 with `if_rdata=0x8C220004`; `stall_if` is high in cycles 0–2.
- **Store:** `d_we=1`, `d_addr=0x100`, `d_wdata=0xDEADBEEF` → `mem_we=1` for 2 cycles, `d_ack` in cycle 3, `d_rdata` unchanged.
- **Tie:** `if_req` and `d_req` raised together and held, both requesters drop `req` on their acks →
  - With the macro: data is acked at cycle 3, fetch at cycle 7.
  - Without the macro: the same order for the first tie; a second simultaneous tie grants IF first.
- **Reset mid-access:** pull `rst_n` low during D_BUSY → `mem_en=0` next cycle, no `d_ack`, `d_rdata=0`.
- **WAIT_CYCLES=1 sweep:** 5 alternating accesses → each acked 2 cycles after grant; throughput of one access per 3 cycles.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//
// Shares one single-port, fixed-latency memory between the instruction-fetch
// stage and the MEM-stage data access of the 4-stage MIPS pipeline. One
// requester is granted at a time. Its command is held on the memory port for
// WAIT_CYCLES cycles, and the read data comes back with a one-cycle
// acknowledge. The block also raises the stall signals that freeze the
// PC/IF-ID path or the whole pipeline while an access is outstanding.
//
// Optional feature macro: ARB_DATA_PRIORITY_EN
//   defined   : on a tie, data always wins (fixed priority).
//   undefined : on a tie, the requester that was not granted last wins
//               (round-robin). After reset the first tie goes to data.
//
// Parameters
//   ADDR_W       address width
//   DATA_W       data width
//   WAIT_CYCLES  memory latency in cycles, 1..15
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   if_req/if_addr                 fetch request and address (held until if_ack)
//   if_rdata/if_ack                fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata      data request (held until d_ack)
//   d_rdata/d_ack                  load data and one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_rdata                      memory read data, valid in last held cycle
//   stall_if                       freeze PC and IF/ID  (if_req & ~if_ack)
//   stall_all                      freeze whole pipeline (d_req & ~d_ack)
module unified_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_all
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Counter is loaded so that it reaches zero in the last held command cycle.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       last_grant;
  logic       grant_if;
  logic       grant_d;
  logic       tie_to_d;

  // Stalls are the only combinational outputs; they drop in the ack cycle.
  assign stall_if  = if_req & ~if_ack;
  assign stall_all = d_req & ~d_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
`ifdef ARB_DATA_PRIORITY_EN
    tie_to_d  = 1'b1;
`else
    tie_to_d  = (last_grant == GRANT_IF);
`endif
    case (state)
      IDLE: begin
        if (d_req && (!if_req || tie_to_d)) begin
          grant_d   = 1'b1;
          state_nxt = D_BUSY;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        // Requests are deliberately ignored here so a requester has one
        // cycle to drop its request after seeing the ack.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      cnt        <= 4'd0;
      last_grant <= GRANT_IF;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_en     <= 1'b1;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            cnt        <= CNT_INIT;
            last_grant <= GRANT_D;
          end else if (grant_if) begin
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            cnt        <= CNT_INIT;
            last_grant <= GRANT_IF;
          end
        end
        IF_BUSY: begin
          if (cnt == 4'd0) begin
            mem_en   <= 1'b0;
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        D_BUSY: begin
          if (cnt == 4'd0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            // A store leaves the previous load data visible.
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            d_ack <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          if_ack, d_ack, mem_en, mem_we, stall_if, stall_all;

  logic          w1_if_req, w1_d_req;
  logic [AW-1:0] w1_if_addr, w1_d_addr, w1_mem_addr;
  logic [DW-1:0] w1_if_rdata, w1_d_rdata, w1_mem_wdata, w1_mem_rdata;
  logic          w1_if_ack, w1_d_ack, w1_mem_en, w1_mem_we, w1_stall_if, w1_stall_all;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] w1_q[$];
  logic [31:0] d_last;
  int          n_total = 0;
  int          n_pass  = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_all(stall_all)
  );

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(w1_if_req), .if_addr(w1_if_addr), .if_rdata(w1_if_rdata), .if_ack(w1_if_ack),
    .d_req(w1_d_req), .d_we(1'b0), .d_addr(w1_d_addr), .d_wdata(32'h0),
    .d_rdata(w1_d_rdata), .d_ack(w1_d_ack),
    .mem_en(w1_mem_en), .mem_we(w1_mem_we), .mem_addr(w1_mem_addr), .mem_wdata(w1_mem_wdata),
    .mem_rdata(w1_mem_rdata), .stall_if(w1_stall_if), .stall_all(w1_stall_all)
  );

  // Memory model: combinational read, write on each held store cycle.
  assign mem_rdata    = mem[mem_addr[9:2]];
  assign w1_mem_rdata = mem[w1_mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Scoreboard: each ack pops the value queued when the request was driven.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_ack) begin
        if (if_q.size() == 0) chk("if_ack_unexpected", 32'd1, 32'd0);
        else chk("if_rdata", if_rdata, if_q.pop_front());
      end
      if (d_ack) begin
        if (d_q.size() == 0) chk("d_ack_unexpected", 32'd1, 32'd0);
        else chk("d_rdata", d_rdata, d_q.pop_front());
      end
      if (w1_if_ack || w1_d_ack) begin
        if (w1_q.size() == 0) chk("w1_ack_unexpected", 32'd1, 32'd0);
        else chk("w1_rdata", w1_if_ack ? w1_if_rdata : w1_d_rdata, w1_q.pop_front());
      end
    end
  end

  task automatic do_access(input vec_t v, input int idx);
    int t, en_cnt, we_cnt, bad;
    bit got;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      if (v.we) ref_mem[v.addr[9:2]] = v.wdata;
      else d_last = ref_mem[v.addr[9:2]];
      d_q.push_back(d_last);
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      if_q.push_back(ref_mem[v.addr[9:2]]);
    end
    t = 0; got = 0; en_cnt = 0; we_cnt = 0; bad = 0;
    while (!got && t < 40) begin
      @(negedge clk);
      t++;
      if (mem_en) begin
        en_cnt++;
        if (mem_we) we_cnt++;
        if (mem_addr !== v.addr || (v.we && mem_wdata !== v.wdata)) bad++;
      end
      if (v.is_d ? d_ack : if_ack) begin
        got = 1;
        chk({tag, "_stall_ack"}, 32'(v.is_d ? stall_all : stall_if), 32'd0);
        if (v.is_d) d_req = 1'b0; else if_req = 1'b0;
      end else if (t == 1) begin
        chk({tag, "_stall_busy"}, 32'(v.is_d ? stall_all : stall_if), 32'd1);
      end
    end
    chk({tag, "_ack_latency"}, 32'(t), 32'(W + 1));
    chk({tag, "_mem_en_cycles"}, 32'(en_cnt), 32'(W));
    chk({tag, "_mem_we_cycles"}, 32'(we_cnt), v.we ? 32'(W) : 32'd0);
    chk({tag, "_mem_cmd"}, 32'(bad), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int t, t_d1, t_d2, t_if, n_dack, n_en, n_acks, prev_ack, nxt;
    logic [31:0] w1_addrs[5];

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i) * 32'h0101;
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    end
    mem[16] = 32'h8C22_0004; ref_mem[16] = 32'h8C22_0004;

    vecs[0] = '{0, 0, 32'h40,  32'h0};
    vecs[1] = '{1, 1, 32'h100, 32'hDEAD_BEEF};
    vecs[2] = '{1, 0, 32'h100, 32'h0};
    vecs[3] = '{0, 0, 32'h44,  32'h0};
    vecs[4] = '{1, 0, 32'h0,   32'h0};
    vecs[5] = '{1, 1, 32'h3FC, 32'hFFFF_FFFF};
    vecs[6] = '{1, 0, 32'h3FC, 32'h0};
    vecs[7] = '{1, 1, 32'h8,   32'h1234_5678};

    rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    w1_if_req = 0; w1_d_req = 0; w1_if_addr = 0; w1_d_addr = 0;
    d_last = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_stalls", {30'd0, stall_if, stall_all}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) do_access(vecs[i], i);

    // Reset in the middle of a data load
    @(negedge clk);
    chk("pre_rst_d_rdata_nonzero", 32'(d_rdata != 32'h0), 32'd1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3FC;
    @(negedge clk);
    chk("midrst_busy_mem_en", 32'(mem_en), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    chk("midrst_d_ack", 32'(d_ack), 32'd0);
    chk("midrst_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    rst_n = 1'b1;
    n_dack = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_ack) n_dack++;
    end
    chk("midrst_no_late_ack", 32'(n_dack), 32'd0);
    d_last = 32'h0;

    // Tie: both raise together; data re-requests right after its first ack
    d_we = 1'b0; d_addr = 32'h100; if_addr = 32'h48;
    d_last = ref_mem[64];
    d_q.push_back(d_last);
    d_q.push_back(d_last);
    if_q.push_back(ref_mem[18]);
    if_req = 1'b1; d_req = 1'b1;
    t = 0; t_d1 = -1; t_d2 = -1; t_if = -1;
    while ((t_d2 < 0 || t_if < 0) && t < 40) begin
      @(negedge clk);
      t++;
      if (t == 1) chk("tie_stalls", {30'd0, stall_if, stall_all}, 32'd3);
      if (d_ack) begin
        if (t_d1 < 0) t_d1 = t; else t_d2 = t;
        d_req = 1'b0;
      end
      if (if_ack) begin
        t_if = t;
        if_req = 1'b0;
      end
      if (t == 4) d_req = 1'b1;
    end
    chk("tie_first_d_ack", 32'(t_d1), 32'd3);
`ifdef ARB_DATA_PRIORITY_EN
    chk("tie_second_d_ack", 32'(t_d2), 32'd7);
    chk("tie_if_ack", 32'(t_if), 32'd11);
`else
    chk("tie_if_ack", 32'(t_if), 32'd7);
    chk("tie_second_d_ack", 32'(t_d2), 32'd11);
`endif
    if_req = 1'b0; d_req = 1'b0;

    // WAIT_CYCLES=1: five alternating back-to-back accesses
    w1_addrs = '{32'h40, 32'h100, 32'h44, 32'h0, 32'h48};
    @(negedge clk);
    w1_if_req = 1'b1; w1_if_addr = w1_addrs[0];
    w1_q.push_back(ref_mem[w1_addrs[0][9:2]]);
    nxt = 1; t = 0; n_en = 0; n_acks = 0; prev_ack = 0;
    while (n_acks < 5 && t < 60) begin
      @(negedge clk);
      t++;
      if (w1_mem_en) n_en++;
      if (w1_if_ack || w1_d_ack) begin
        n_acks++;
        if (n_acks == 1) chk("w1_first_latency", 32'(t), 32'd2);
        else chk($sformatf("w1_ack_gap%0d", n_acks), 32'(t - prev_ack), 32'd3);
        prev_ack = t;
        w1_if_req = 1'b0; w1_d_req = 1'b0;
        if (nxt < 5) begin
          if (nxt % 2 == 1) begin w1_d_req = 1'b1; w1_d_addr = w1_addrs[nxt]; end
          else begin w1_if_req = 1'b1; w1_if_addr = w1_addrs[nxt]; end
          w1_q.push_back(ref_mem[w1_addrs[nxt][9:2]]);
          nxt++;
        end
      end
    end
    chk("w1_ack_count", 32'(n_acks), 32'd5);
    chk("w1_mem_en_cycles", 32'(n_en), 32'd5);

    repeat (2) @(negedge clk);
    chk("queues_drained", 32'(if_q.size() + d_q.size() + w1_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
